// File: rtl/fft32_tb_pkg.sv
// -----------------------------------------------------------------------------
// fft32_tb_pkg
// Shared definitions for the fft32 AXI-Stream exerciser: default stream width
// and frame length, the exerciser state encoding and the bit positions
// inside the stall_src flag.
// No ports (package).
// -----------------------------------------------------------------------------
package fft32_tb_pkg;

    // TDATA layout is {imag[31:0], real[31:0]}
    localparam int FFT_DATA_W    = 64;
    localparam int FFT_FRAME_LEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_STALL = 2'd3
    } state_t;

    // stall_src bit meaning
    localparam int STALL_SRC_IN  = 0;  // in_stream offered but not accepted
    localparam int STALL_SRC_OUT = 1;  // frames outstanding, nothing returned

endpackage

// File: rtl/fft32_axis_throttle.sv
// -----------------------------------------------------------------------------
// fft32_axis_throttle
// 8-bit rotating gate pattern. Loaded in one cycle, then rotated right by one
// position on every enabled cycle; bit 0 is the current gate.
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset (clears the pattern)
//   load         in   load load_pattern this cycle (has priority over en)
//   load_pattern in 8 pattern to load
//   en           in   rotate right this cycle
//   gate         out  current pattern bit 0
// -----------------------------------------------------------------------------
module fft32_axis_throttle (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_pattern,
    input  logic       en,
    output logic       gate
);

    logic [7:0] pattern;

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern <= 8'h00;
        end else if (load) begin
            pattern <= load_pattern;
        end else if (en) begin
            pattern <= {pattern[0], pattern[7:1]};
        end
    end

    assign gate = pattern[0];

endmodule

// File: rtl/fft32_axis_stream_exerciser.sv
// -----------------------------------------------------------------------------
// fft32_axis_stream_exerciser
// Bring-up companion for the fft32 kernel: sources numbered FRAME_LEN-sample
// frames into the kernel's in_stream, sinks its out_stream with programmable
// backpressure, counts frames both ways, checks TLAST placement and runs a
// progress watchdog that reports which side stopped moving.
// Ports:
//   ap_clk, ap_rst            clock, synchronous active-high reset
//   start                     one-cycle pulse, begins a run from IDLE
//   num_frames[15:0]          frames per run (latched on start)
//   vld_pattern[7:0]          source valid throttle (latched on start)
//   rdy_pattern[7:0]          sink ready throttle (latched on start)
//   in_stream_T*              AXI-Stream master towards the kernel
//   out_stream_T*             AXI-Stream slave from the kernel
//   busy                      run in progress
//   done                      one-cycle completion pulse
//   frames_sent, frames_recv  completed frame counters
//   tlast_err                 sticky TLAST misplacement flag
//   stall, stall_src[1:0]     sticky watchdog flag and its cause
// -----------------------------------------------------------------------------
module fft32_axis_stream_exerciser
    import fft32_tb_pkg::*;
#(
    parameter int DATA_W      = FFT_DATA_W,
    parameter int FRAME_LEN   = FFT_FRAME_LEN,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              start,
    input  logic [15:0]       num_frames,
    input  logic [7:0]        vld_pattern,
    input  logic [7:0]        rdy_pattern,
    output logic [DATA_W-1:0] in_stream_TDATA,
    output logic              in_stream_TVALID,
    input  logic              in_stream_TREADY,
    output logic              in_stream_TLAST,
    input  logic [DATA_W-1:0] out_stream_TDATA,
    input  logic              out_stream_TVALID,
    output logic              out_stream_TREADY,
    input  logic              out_stream_TLAST,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frames_sent,
    output logic [15:0]       frames_recv,
    output logic              tlast_err,
    output logic              stall,
    output logic [1:0]        stall_src
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int WD_W  = $clog2(WDOG_CYCLES) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(WDOG_CYCLES - 1);

    state_t            state, state_next;
    logic [15:0]       num_q;
    logic [15:0]       sent_q, recv_q;
    logic [15:0]       sent_next, recv_next;
    logic [IDX_W-1:0]  sample_idx, beat_idx;
    logic [WD_W-1:0]   wd_q, wd_inc;
    logic              tvalid_q, tready_q;
    logic              tvalid_next, tready_next;
    logic              tlast_err_q, stall_q;
    logic [1:0]        stall_src_q;
    logic              vld_gate, rdy_gate;
    logic              accept_start, stay_run;
    logic              hs_in, hs_out, last_in, wd_expire;
    logic              unused_tdata;

    // The kernel's result data is not inspected here
    assign unused_tdata = ^out_stream_TDATA;

    assign accept_start = (state == ST_IDLE) && start;

    fft32_axis_throttle u_vld_throttle (
        .clk          (ap_clk),
        .rst          (ap_rst),
        .load         (accept_start),
        .load_pattern (vld_pattern),
        .en           (state == ST_RUN),
        .gate         (vld_gate)
    );

    fft32_axis_throttle u_rdy_throttle (
        .clk          (ap_clk),
        .rst          (ap_rst),
        .load         (accept_start),
        .load_pattern (rdy_pattern),
        .en           (state == ST_RUN),
        .gate         (rdy_gate)
    );

    assign hs_in     = tvalid_q & in_stream_TREADY;
    assign hs_out    = out_stream_TVALID & tready_q;
    assign last_in   = (sample_idx == LAST_IDX);
    assign sent_next = sent_q + 16'(hs_in & last_in);
    assign recv_next = recv_q + 16'(hs_out & out_stream_TLAST);
    assign wd_inc    = wd_q + WD_W'(1);
    // Expiry fires on the edge that would load WDOG_CYCLES-1 into the counter
    assign wd_expire = (state == ST_RUN) && !(hs_in || hs_out) && (wd_inc == WD_LIMIT);

    // ---- state register ----
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---- next state, status and next handshake controls ----
    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        stay_run    = 1'b0;
        tvalid_next = 1'b0;
        tready_next = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (num_frames == 16'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // A final receive beats a simultaneous watchdog expiry
                if (recv_next == num_q) begin
                    state_next = ST_DONE;
                end else if (wd_expire) begin
                    state_next = ST_STALL;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_STALL: state_next = ST_STALL;
            default:  state_next = ST_IDLE;
        endcase

        busy     = (state == ST_RUN);
        done     = (state == ST_DONE);
        stay_run = (state == ST_RUN) && (state_next == ST_RUN);

        if (stay_run) begin
            // An offered beat is never withdrawn; the pattern only gates new offers
            if (tvalid_q && !in_stream_TREADY) begin
                tvalid_next = 1'b1;
            end else begin
                tvalid_next = (sent_next < num_q) && vld_gate;
            end
            tready_next = (recv_next < num_q) && rdy_gate;
        end
    end

    // ---- counters, handshake registers, watchdog ----
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            num_q       <= 16'd0;
            sent_q      <= 16'd0;
            recv_q      <= 16'd0;
            sample_idx  <= '0;
            beat_idx    <= '0;
            tvalid_q    <= 1'b0;
            tready_q    <= 1'b0;
            tlast_err_q <= 1'b0;
            stall_q     <= 1'b0;
            stall_src_q <= 2'b00;
            wd_q        <= '0;
        end else begin
            if (accept_start) begin
                num_q       <= num_frames;
                sent_q      <= 16'd0;
                recv_q      <= 16'd0;
                sample_idx  <= '0;
                beat_idx    <= '0;
                tlast_err_q <= 1'b0;
            end else begin
                if (hs_in) begin
                    sample_idx <= last_in ? '0 : sample_idx + IDX_W'(1);
                    sent_q     <= sent_next;
                end
                if (hs_out) begin
                    // beat_idx only realigns on a received TLAST
                    beat_idx <= out_stream_TLAST ? '0 : beat_idx + IDX_W'(1);
                    recv_q   <= recv_next;
                    if (out_stream_TLAST != (beat_idx == LAST_IDX)) begin
                        tlast_err_q <= 1'b1;
                    end
                end
            end

            tvalid_q <= tvalid_next;
            tready_q <= tready_next;

            if ((state != ST_RUN) || hs_in || hs_out) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_inc;
            end

            if ((state == ST_RUN) && (state_next == ST_STALL)) begin
                stall_q                    <= 1'b1;
                stall_src_q[STALL_SRC_IN]  <= tvalid_q & ~in_stream_TREADY;
                stall_src_q[STALL_SRC_OUT] <= (recv_q < sent_q) & ~out_stream_TVALID;
            end
        end
    end

    assign in_stream_TDATA   = DATA_W'({32'(sample_idx), 16'h0000, sent_q});
    assign in_stream_TVALID  = tvalid_q;
    assign in_stream_TLAST   = last_in;
    assign out_stream_TREADY = tready_q;
    assign frames_sent       = sent_q;
    assign frames_recv       = recv_q;
    assign tlast_err         = tlast_err_q;
    assign stall             = stall_q;
    assign stall_src         = stall_src_q;

endmodule

// File: tb/tb_fft32_axis_stream_exerciser.sv
// -----------------------------------------------------------------------------
// tb_fft32_axis_stream_exerciser
// Scoreboard bench: each start pushes the full expected beat sequence and the
// expected completion counters; a negedge monitor plays the kernel (loopback
// FIFO with optional frame corruption) and pops/compares on every handshake
// and every done pulse.
// -----------------------------------------------------------------------------
module tb_fft32_axis_stream_exerciser;

    localparam int DW = 64;
    localparam int FL = 32;
    localparam int WD = 16;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [15:0] sent;
        logic [15:0] recv;
        logic        err;
    } res_t;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   num_frames = 16'd0;
    logic [7:0]    vld_pattern = 8'h00;
    logic [7:0]    rdy_pattern = 8'h00;
    logic [DW-1:0] in_stream_TDATA;
    logic          in_stream_TVALID;
    logic          in_stream_TREADY = 1'b0;
    logic          in_stream_TLAST;
    logic [DW-1:0] out_stream_TDATA = '0;
    logic          out_stream_TVALID = 1'b0;
    logic          out_stream_TREADY;
    logic          out_stream_TLAST = 1'b0;
    logic          busy, done;
    logic [15:0]   frames_sent, frames_recv;
    logic          tlast_err, stall;
    logic [1:0]    stall_src;

    int n_tests = 0;
    int n_fail  = 0;

    beat_t exp_q[$];
    res_t  res_q[$];
    bit    fifo_q[$];

    int    k_in_mode  = 1;   // 0 never ready, 1 always, 2 random
    int    k_out_mode = 1;   // 1 always valid when data, 2 random
    int    force_low  = 0;
    bit    mangle_f0  = 1'b0;
    int    in_hs_cnt  = 0;
    int    done_cnt   = 0;
    int    done_base  = 0;
    bit    prev_tv = 1'b0, prev_tr = 1'b0;
    logic [63:0] prev_data = '0;
    beat_t mon_e;
    res_t  mon_r;
    bit    mon_rdy, mon_ov;

    fft32_axis_stream_exerciser #(
        .DATA_W      (DW),
        .FRAME_LEN   (FL),
        .WDOG_CYCLES (WD)
    ) dut (
        .ap_clk            (ap_clk),
        .ap_rst            (ap_rst),
        .start             (start),
        .num_frames        (num_frames),
        .vld_pattern       (vld_pattern),
        .rdy_pattern       (rdy_pattern),
        .in_stream_TDATA   (in_stream_TDATA),
        .in_stream_TVALID  (in_stream_TVALID),
        .in_stream_TREADY  (in_stream_TREADY),
        .in_stream_TLAST   (in_stream_TLAST),
        .out_stream_TDATA  (out_stream_TDATA),
        .out_stream_TVALID (out_stream_TVALID),
        .out_stream_TREADY (out_stream_TREADY),
        .out_stream_TLAST  (out_stream_TLAST),
        .busy              (busy),
        .done              (done),
        .frames_sent       (frames_sent),
        .frames_recv       (frames_recv),
        .tlast_err         (tlast_err),
        .stall             (stall),
        .stall_src         (stall_src)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Kernel model and scoreboard monitor; all kernel-side inputs change here
    always @(negedge ap_clk) begin
        if (ap_rst) begin
            fifo_q.delete();
            in_stream_TREADY  = 1'b0;
            out_stream_TVALID = 1'b0;
            out_stream_TLAST  = 1'b0;
            out_stream_TDATA  = '0;
            prev_tv = 1'b0;
            prev_tr = 1'b0;
        end else begin
            if (prev_tv && !prev_tr && busy) begin
                check("hold_tvalid", 64'(in_stream_TVALID), 64'd1);
                check("hold_tdata", in_stream_TDATA, prev_data);
            end

            case (k_in_mode)
                0:       mon_rdy = 1'b0;
                1:       mon_rdy = 1'b1;
                default: mon_rdy = ($urandom_range(0, 4) != 0);
            endcase
            if (force_low > 0) begin
                mon_rdy = 1'b0;
                force_low--;
            end
            in_stream_TREADY = mon_rdy;

            mon_ov = (fifo_q.size() > 0) && ((k_out_mode == 1) || ($urandom_range(0, 4) != 0));
            out_stream_TVALID = mon_ov;
            out_stream_TLAST  = mon_ov ? fifo_q[0] : 1'b0;
            out_stream_TDATA  = {$urandom, $urandom};
            if (mon_ov && out_stream_TREADY) void'(fifo_q.pop_front());

            if (in_stream_TVALID && mon_rdy) begin
                in_hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL in_beat_unexpected: got beat %0h, required no beat", in_stream_TDATA);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("in_tdata", in_stream_TDATA, mon_e.data);
                    check("in_tlast", 64'(in_stream_TLAST), 64'(mon_e.last));
                    // Loopback; optionally frame 0 comes back one beat short
                    if (mangle_f0 && (mon_e.data[15:0] == 16'd0)) begin
                        if (mon_e.data[36:32] != 5'd31) fifo_q.push_back(mon_e.data[36:32] == 5'd30);
                    end else begin
                        fifo_q.push_back(mon_e.last);
                    end
                end
            end

            if (done) begin
                done_cnt++;
                if (res_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL done_unexpected: got done=1, required done=0");
                end else begin
                    mon_r = res_q.pop_front();
                    check("done_frames_sent", 64'(frames_sent), 64'(mon_r.sent));
                    check("done_frames_recv", 64'(frames_recv), 64'(mon_r.recv));
                    check("done_tlast_err", 64'(tlast_err), 64'(mon_r.err));
                end
            end

            prev_tv   = in_stream_TVALID;
            prev_tr   = mon_rdy;
            prev_data = in_stream_TDATA;
        end
    end

    task automatic do_reset();
        @(posedge ap_clk); #1;
        ap_rst = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
    endtask

    task automatic check_idle(input string p);
        check({p, "_tvalid"}, 64'(in_stream_TVALID), 64'd0);
        check({p, "_tready"}, 64'(out_stream_TREADY), 64'd0);
        check({p, "_tlast"}, 64'(in_stream_TLAST), 64'd0);
        check({p, "_tdata"}, in_stream_TDATA, 64'd0);
        check({p, "_busy"}, 64'(busy), 64'd0);
        check({p, "_done"}, 64'(done), 64'd0);
        check({p, "_sent"}, 64'(frames_sent), 64'd0);
        check({p, "_recv"}, 64'(frames_recv), 64'd0);
        check({p, "_tlast_err"}, 64'(tlast_err), 64'd0);
        check({p, "_stall"}, 64'(stall), 64'd0);
        check({p, "_stall_src"}, 64'(stall_src), 64'd0);
    endtask

    task automatic run_start(input int n, input logic [7:0] vp, input logic [7:0] rp,
                             input bit mangle, input bit expect_done);
        beat_t b;
        res_t  r;
        for (int f = 0; f < n; f++) begin
            for (int s = 0; s < FL; s++) begin
                b.data = {32'(s), 16'h0000, 16'(f)};
                b.last = (s == FL - 1);
                exp_q.push_back(b);
            end
        end
        if (expect_done) begin
            r.sent = 16'(n);
            r.recv = 16'(n);
            r.err  = mangle;
            res_q.push_back(r);
        end
        mangle_f0 = mangle;
        in_hs_cnt = 0;
        done_base = done_cnt;
        @(posedge ap_clk); #1;
        num_frames  = 16'(n);
        vld_pattern = vp;
        rdy_pattern = rp;
        start       = 1'b1;
        @(posedge ap_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > done_base) break;
            @(posedge ap_clk); #1;
        end
        check({name, "_done_seen"}, 64'(done_cnt > done_base), 64'd1);
        check({name, "_beats_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_results_left"}, 64'(res_q.size()), 64'd0);
        check({name, "_kernel_fifo"}, 64'(fifo_q.size()), 64'd0);
        check({name, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no summary, required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        logic [7:0] vp, rp;

        do_reset();
        check_idle("reset");

        // Full-rate loopback, three frames
        k_in_mode  = 1;
        k_out_mode = 1;
        run_start(3, 8'hFF, 8'hFF, 1'b0, 1'b1);
        wait_done("loopback", 2000);
        check("loopback_in_beats", 64'(in_hs_cnt), 64'd96);

        // Sparse valid pattern plus a 5-cycle kernel stall while a beat is held
        k_out_mode = 2;
        run_start(2, 8'h55, 8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            if (in_hs_cnt >= 10 && in_stream_TVALID) break;
            @(posedge ap_clk); #1;
        end
        check("throttle_reached_mid", 64'(in_hs_cnt >= 10 && in_stream_TVALID), 64'd1);
        force_low = 5;
        wait_done("throttle", 3000);

        // Randomised throttling on both sides
        k_in_mode  = 2;
        k_out_mode = 2;
        for (int it = 0; it < 4; it++) begin
            n  = $urandom_range(1, 3);
            vp = 8'($urandom) | 8'h55;
            rp = 8'($urandom) | 8'h55;
            run_start(n, vp, rp, 1'b0, 1'b1);
            wait_done("random", 3000);
        end

        // Kernel closes frame 0 on beat 30
        k_in_mode  = 1;
        k_out_mode = 1;
        run_start(2, 8'hFF, 8'hFF, 1'b1, 1'b1);
        wait_done("tlast_short", 2000);
        mangle_f0 = 1'b0;

        // Zero-frame run
        run_start(0, 8'hFF, 8'hFF, 1'b0, 1'b1);
        @(negedge ap_clk);
        check("zero_done_pulse", 64'(done), 64'd1);
        check("zero_tvalid_0", 64'(in_stream_TVALID), 64'd0);
        @(negedge ap_clk);
        check("zero_done_low", 64'(done), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge ap_clk);
            check("zero_tvalid", 64'(in_stream_TVALID), 64'd0);
        end
        check("zero_done_count", 64'(done_cnt - done_base), 64'd1);

        // Kernel never accepts: watchdog fires in the 16th RUN cycle
        k_in_mode = 0;
        run_start(1, 8'hFF, 8'hFF, 1'b0, 1'b0);
        repeat (15) @(negedge ap_clk);
        check("wdog_not_yet", 64'(stall), 64'd0);
        @(negedge ap_clk);
        check("wdog_stall", 64'(stall), 64'd1);
        check("wdog_stall_src", 64'(stall_src), 64'd1);
        check("wdog_busy", 64'(busy), 64'd0);
        check("wdog_tvalid", 64'(in_stream_TVALID), 64'd0);
        check("wdog_tready", 64'(out_stream_TREADY), 64'd0);
        repeat (5) @(negedge ap_clk);
        check("wdog_stall_held", 64'(stall), 64'd1);
        exp_q.delete();
        do_reset();
        check_idle("after_stall");

        // Reset while sample 12 of frame 0 is on the bus
        k_in_mode = 1;
        run_start(2, 8'hFF, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 500; i++) begin
            if (in_hs_cnt >= 12) break;
            @(posedge ap_clk); #1;
        end
        check("midrst_reached", 64'(in_hs_cnt), 64'd12);
        ap_rst = 1'b1;
        @(posedge ap_clk); #1;
        check_idle("midrst");
        ap_rst = 1'b0;
        exp_q.delete();
        res_q.delete();
        run_start(1, 8'hFF, 8'hFF, 1'b0, 1'b1);
        wait_done("after_midrst", 2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft32_axis_stream_exerciser.md
Name: fft32_axis_stream_exerciser

Overview:
- Drives the kernel's AXI-Stream ports from the opposite end: acts as master for fft32 in_stream and as slave for fft32 out_stream.
- Generates numbered 32-sample frames, applies programmable valid/ready throttling, and counts and checks returned frames.
- Runs a progress watchdog that flags which side of the kernel stopped moving.
- Sits in the fft32 simulation/bring-up harness beside the kernel instance, sharing its clock and reset.

Parameters:
- DATA_W, 64, TDATA width; {imag[31:0], real[31:0]}.
- FRAME_LEN, 32, samples per frame; must be a power of two.
- WDOG_CYCLES, 4096, handshake-free RUN cycles before declaring a stall.

Ports:
- ap_clk  in  1  sole clock.
- ap_rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when IDLE.
- num_frames  in  16  frames to send and receive; sampled on start.
- vld_pattern  in  8  in_stream throttle pattern; sampled on start, rotated right each cycle.
- rdy_pattern  in  8  out_stream backpressure pattern; same handling.
- in_stream_TDATA  out  DATA_W  generated sample.
- in_stream_TVALID  out  1  source valid.
- in_stream_TREADY  in  1  kernel ready.
- in_stream_TLAST  out  1  high on sample FRAME_LEN-1.
- out_stream_TDATA  in  DATA_W  kernel result (not checked).
- out_stream_TVALID  in  1  kernel valid.
- out_stream_TREADY  out  1  sink ready.
- out_stream_TLAST  in  1  kernel end of frame.
- busy  out  1  state is RUN.
- done  out  1  one-cycle pulse at run completion.
- frames_sent  out  16  completed input frames.
- frames_recv  out  16  completed output frames.
- tlast_err  out  1  sticky TLAST misplacement flag.
- stall  out  1  sticky watchdog flag.
- stall_src  out  2  bit0 = in_stream blocked; bit1 = out_stream starved.

Behaviour:
- Reset (ap_rst): state IDLE; all outputs 0, including in_stream_TVALID and out_stream_TREADY; counters cleared; patterns cleared. Reset mid-run aborts immediately, with no partial-frame completion.
- States: IDLE, RUN, DONE, STALL.
  - IDLE + start: num_frames == 0 -> DONE; otherwise -> RUN.
  - RUN, frames_recv == num_frames -> DONE.
  - RUN, watchdog expiry -> STALL.
  - DONE -> IDLE after 1 cycle; done = 1 only in DONE.
  - STALL is held until ap_rst.
  - start is ignored outside IDLE.
- Starting a run: frames_sent, frames_recv, tlast_err, sample index and beat index are all cleared.
- Source:
  - The next beat is offered when in RUN, frames_sent < num_frames, and vld_pattern bit0 = 1.
  - Once TVALID = 1, TVALID and TDATA hold unchanged until TREADY. The pattern gates only new assertions, never withdrawal.
  - TDATA: real = {16'b0, frames_sent}; imag = {27'b0, sample_idx[4:0]}.
  - TLAST = (sample_idx == FRAME_LEN-1).
  - On a handshake: sample_idx increments and wraps to 0 after the last sample; frames_sent increments on the TLAST beat. A new beat may issue in the cycle after a handshake.
- Sink:
  - out_stream_TREADY = RUN & (frames_recv < num_frames) & rdy_pattern bit0. Registered: computed from the pattern state of the previous cycle.
  - On a handshake: beat_idx increments.
  - TLAST with beat_idx != FRAME_LEN-1, or no TLAST at beat FRAME_LEN-1: set tlast_err.
  - Resynchronisation: frames_recv increments, and beat_idx resets to 0, only on a received TLAST.
- Watchdog:
  - The counter clears on any handshake on either port, and in any non-RUN state.
  - It increments every RUN cycle otherwise; when it reaches WDOG_CYCLES-1 the block enters STALL.
  - On entering STALL: stall = 1; stall_src[0] = in_stream_TVALID & ~in_stream_TREADY; stall_src[1] = (frames_recv < frames_sent) & ~out_stream_TVALID.
  - In STALL: TVALID and TREADY drop to 0.
- Simultaneous events:
  - A source and sink handshake in the same cycle are both counted.
  - The final receive and watchdog expiry in the same cycle: completion wins and the block goes to DONE.
- Counter widths: 16-bit counters, no wrap concern (num_frames ≤ 65535).

Decomposition:
- Shared package fft32_tb_pkg: DATA_W and FRAME_LEN constants, the state enum, and the stall_src bit indices.
- One natural sub-module, fft32_axis_throttle: an 8-bit rotating pattern register with load and enable, instantiated twice (valid and ready).

Test Plan:
- Loopback model, num_frames = 3, both patterns 8'hFF -> 96 beats, TLAST on beats 31/63/95, done after frames_recv = 3, tlast_err = 0.
- vld_pattern = 8'h55, kernel TREADY low for 5 cycles mid-beat -> TVALID/TDATA held stable across the stall, no lost or duplicated sample_idx.
- Kernel never asserts in_stream_TREADY, WDOG_CYCLES = 16 -> stall = 1 at cycle 16 of RUN, stall_src = 2'b01, busy = 0.
- Kernel returns TLAST on beat 30 -> tlast_err = 1, frames_recv = 1, next frame counted from beat 0.
- num_frames = 0 with start -> done pulses the following cycle, no TVALID ever asserted.
- ap_rst asserted mid-frame (sample 12) -> next cycle all outputs 0; a new start sends frame 0 from sample 0.
